// File: rtl/axil_read_slave.sv
// AXI4-Lite read-channel responder (AR/R slave).
// Accepts one read at a time, decodes it against [ADDR_LO, ADDR_HI], strobes a
// simple user-side register read port and returns the user data on R. Reads
// outside the window are answered with DECERR without touching the user port;
// a user port that stays silent for TIMEOUT cycles is answered with SLVERR.
module axil_read_slave #(
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_0FFF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    // AR channel
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    // R channel
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    // user register read port
    output logic [31:0] usr_raddr,
    output logic        usr_rreq,
    input  logic [31:0] usr_rdata,
    input  logic        usr_rdv,
    // status
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    // Counter value on the last WAIT cycle before giving up (TIMEOUT <= 255).
    localparam logic [7:0]  CNT_LAST    = 8'(TIMEOUT - 1);

    // Window width; an address is inside when (addr - ADDR_LO) <= SPAN using
    // wrapping unsigned arithmetic, which also behaves when ADDR_LO is zero.
    localparam logic [31:0] SPAN        = ADDR_HI - ADDR_LO;

    state_t      state_q,     state_d;
    logic        arready_q,   arready_d;
    logic        rvalid_q,    rvalid_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [1:0]  rresp_q,     rresp_d;
    logic [31:0] usr_raddr_q, usr_raddr_d;
    logic        usr_rreq_q,  usr_rreq_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [15:0] err_cnt_q,   err_cnt_d;

    logic        addr_hit;
    logic        err_load;

    assign addr_hit = ((s_axi_araddr - ADDR_LO) <= SPAN);

    // Next-state and registered-output logic for the single-outstanding FSM.
    always_comb begin
        state_d     = state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        usr_raddr_d = usr_raddr_q;
        usr_rreq_d  = 1'b0;
        cnt_d       = cnt_q;
        err_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arready_q && s_axi_arvalid) begin
                    usr_raddr_d = s_axi_araddr;
                    arready_d   = 1'b0;
                    if (addr_hit) begin
                        usr_rreq_d = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = ST_WAIT;
                    end else begin
                        rdata_d  = 32'd0;
                        rresp_d  = RESP_DECERR;
                        rvalid_d = 1'b1;
                        err_load = 1'b1;
                        state_d  = ST_RESP;
                    end
                end else begin
                    // Also raises arready on the first edge after reset.
                    arready_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // Data arriving on the final timeout cycle still wins.
                if (usr_rdv) begin
                    rdata_d  = usr_rdata;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = 32'd0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                    err_load = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                // R payload is held until the master takes it.
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (err_load && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State and output registers; async reset discards any pending response.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= ST_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= RESP_OKAY;
            usr_raddr_q <= 32'd0;
            usr_rreq_q  <= 1'b0;
            cnt_q       <= 8'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            usr_raddr_q <= usr_raddr_d;
            usr_rreq_q  <= usr_rreq_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign usr_raddr     = usr_raddr_q;
    assign usr_rreq      = usr_rreq_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axil_read_slave.sv
// Directed bench for axil_read_slave: expected R beats are queued when a read
// is issued and popped by a monitor whenever an R handshake is about to occur.
module tb_axil_read_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] usr_raddr;
    logic        usr_rreq;
    logic [31:0] usr_rdata;
    logic        usr_rdv;
    logic [15:0] err_cnt;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    axil_read_slave #(
        .ADDR_LO (32'h0000_0000),
        .ADDR_HI (32'h0000_0FFF),
        .TIMEOUT (16)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .usr_raddr     (usr_raddr),
        .usr_rreq      (usr_rreq),
        .usr_rdata     (usr_rdata),
        .usr_rdv       (usr_rdv),
        .err_cnt       (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.data = d;
        e.resp = r;
        sb.push_back(e);
    endtask

    // Scoreboard: a beat seen with rvalid&rready at negedge is taken at the next posedge.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("r_data", rdata, e.data);
                chk("r_resp", 32'(rresp), 32'(e.resp));
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_arready"}, 32'(arready), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_rresp"}, 32'(rresp), 32'd0);
        chk({tag, "_usr_raddr"}, usr_raddr, 32'd0);
        chk({tag, "_usr_rreq"}, 32'(usr_rreq), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Issue one AR; returns 1ns after the handshake edge.
    task automatic do_ar(input logic [31:0] a);
        int n;
        n = 0;
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_ready_wait", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Wait (bounded) for the R handshake; returns 1ns after that edge.
    task automatic finish_read();
        int n;
        n = 0;
        @(negedge clk);
        while (!(rvalid && rready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("r_hs_wait", 32'(rvalid && rready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int low;
        rst_n     = 1'b0;
        araddr    = 32'd0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        usr_rdata = 32'd0;
        usr_rdv   = 1'b0;

        // Reset values, then arready rises on the first edge after release.
        #12;
        chk_reset("rst0");
        rst_n = 1'b1;
        #1;
        chk("rst0_arready_pre", 32'(arready), 32'd0);
        @(negedge clk);
        chk("rst0_arready_post", 32'(arready), 32'd1);

        // In range, immediate data, rready held high.
        rready    = 1'b1;
        usr_rdv   = 1'b1;
        usr_rdata = 32'hDEADBEEF;
        push(32'hDEADBEEF, 2'b00);
        do_ar(32'h10);
        @(negedge clk);
        chk("t1_usr_raddr", usr_raddr, 32'h10);
        chk("t1_rreq_hi", 32'(usr_rreq), 32'd1);
        chk("t1_rvalid_lo", 32'(rvalid), 32'd0);
        chk("t1_arready_lo", 32'(arready), 32'd0);
        @(negedge clk);
        chk("t1_rvalid_hi", 32'(rvalid), 32'd1);
        chk("t1_rreq_lo", 32'(usr_rreq), 32'd0);
        @(negedge clk);
        chk("t1_rvalid_drop", 32'(rvalid), 32'd0);
        chk("t1_arready_back", 32'(arready), 32'd1);
        usr_rdv = 1'b0;

        // Delayed data (5 cycles after rreq) with 3 cycles of R backpressure.
        rready = 1'b0;
        push(32'hCAFEF00D, 2'b00);
        do_ar(32'h20);
        low = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rvalid) low++;
        end
        chk("t2_rvalid_wait_lo", 32'(low), 32'd5);
        @(posedge clk); #1;
        usr_rdv   = 1'b1;
        usr_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        usr_rdv   = 1'b0;
        usr_rdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_rvalid_held", 32'(rvalid), 32'd1);
            chk("t2_rdata_held", rdata, 32'hCAFEF00D);
            chk("t2_rresp_held", 32'(rresp), 32'd0);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        finish_read();
        @(negedge clk);
        chk("t2_rvalid_done", 32'(rvalid), 32'd0);
        chk("t2_err_cnt", 32'(err_cnt), 32'd0);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Out of range: DECERR on the next edge, no user strobe.
        push(32'h0, 2'b11);
        do_ar(32'h1000);
        @(negedge clk);
        chk("t3_rreq_lo", 32'(usr_rreq), 32'd0);
        chk("t3_rvalid_hi", 32'(rvalid), 32'd1);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk);
        chk("t3_rvalid_drop", 32'(rvalid), 32'd0);

        // Timeout: 16 silent WAIT cycles -> SLVERR; late data is dropped.
        rready = 1'b0;
        push(32'h0, 2'b10);
        do_ar(32'h30);
        low = 0;
        repeat (16) begin
            @(negedge clk);
            if (!rvalid) low++;
        end
        chk("t4_wait_cycles", 32'(low), 32'd16);
        @(negedge clk);
        chk("t4_rvalid_hi", 32'(rvalid), 32'd1);
        chk("t4_rresp", 32'(rresp), 32'd2);
        chk("t4_rdata", rdata, 32'd0);
        chk("t4_err_cnt", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;
        usr_rdv   = 1'b1;
        usr_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("t4_late_ignored", rdata, 32'd0);
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        usr_rdv = 1'b0;
        @(negedge clk);
        chk("t4_rvalid_done", 32'(rvalid), 32'd0);
        push(32'h12345678, 2'b00);
        usr_rdata = 32'h12345678;
        usr_rdv   = 1'b1;
        do_ar(32'h40);
        finish_read();
        usr_rdv = 1'b0;
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Data on WAIT cycle 16 beats the timeout.
        push(32'hA5A5A5A5, 2'b00);
        do_ar(32'hFFC);
        repeat (15) @(posedge clk);
        #1;
        usr_rdv   = 1'b1;
        usr_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        usr_rdv = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_hi", 32'(rvalid), 32'd1);
        chk("t5_rresp_ok", 32'(rresp), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;

        // Window edges: ADDR_HI is OKAY, ADDR_HI+1 is DECERR.
        push(32'h11112222, 2'b00);
        usr_rdata = 32'h11112222;
        usr_rdv   = 1'b1;
        do_ar(32'hFFF);
        finish_read();
        usr_rdv = 1'b0;
        push(32'h0, 2'b11);
        do_ar(32'h1000);
        finish_read();
        chk("t5_err_cnt_edge", 32'(err_cnt), 32'd3);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Async reset while in WAIT.
        rready = 1'b0;
        do_ar(32'h50);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_wait_arready_pre", 32'(arready), 32'd0);
        @(negedge clk);
        chk("rst_wait_arready_post", 32'(arready), 32'd1);

        // Async reset while an R beat is pending.
        do_ar(32'h2000);
        #1;
        chk("rst_resp_pending", 32'(rvalid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_resp");
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_resp_arready_post", 32'(arready), 32'd1);

        // Fresh read after reset completes normally.
        rready    = 1'b1;
        usr_rdv   = 1'b1;
        usr_rdata = 32'h0BADF00D;
        push(32'h0BADF00D, 2'b00);
        do_ar(32'h44);
        finish_read();
        usr_rdv = 1'b0;
        chk("t6_usr_raddr", usr_raddr, 32'h44);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
